mx_scoreboard: RTL and testbench
================================

Name: mx_scoreboard

Overview:
- Per-issue-slice register scoreboard directly downstream of the instruction buffer; consumes one buffered (micro-)instruction per cycle.
- Blocks an instruction while any register it reads or writes has a pending writeback from its warp.
- Marks the destination busy on issue and forwards the instruction through a one-entry output register to operand collection.
- Clears busy bits on writeback-release events from the commit path.

Parameters:
- NUM_WARPS, 4, warps served by this slice; WID_W = max(1, clog2(NUM_WARPS)).
- NUM_REGS, 32, architectural registers per warp; NR_BITS = clog2(NUM_REGS).
- DATAW, 64, width of opaque payload carried alongside the instruction.
- TIMEOUT, 1023, stall cycles before the deadlock flag is raised.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction from ibuffer valid
- in_ready  out  1  scoreboard accepts instruction
- in_wid  in  WID_W  warp id
- in_wb  in  1  instruction writes rd
- in_rd  in  NR_BITS  destination register
- in_rs1, in_rs2, in_rs3  in  NR_BITS each  source registers
- in_rs_used  in  3  bit k set: rs(k+1) is read
- in_data  in  DATAW  opaque payload
- out_valid  out  1  issued instruction valid
- out_ready  in  1  downstream accepts
- out_wid  out  WID_W  registered in_wid
- out_wb  out  1  registered in_wb
- out_rd  out  NR_BITS  registered in_rd
- out_data  out  DATAW  registered in_data
- wb_valid  in  1  writeback event
- wb_wid  in  WID_W  writeback warp
- wb_rd  in  NR_BITS  writeback register
- wb_eop  in  1  last writeback of instruction; release busy bit
- pending  out  NUM_WARPS  bit w set: warp w has at least one busy register
- deadlock  out  1  sticky stall-timeout flag

Behaviour:
- State: busy table NUM_WARPS x NUM_REGS bits; output register (valid + fields); stall counter, 10+ bits, saturating at TIMEOUT; deadlock flag.
- Reset: table all 0; out_valid=0; out_wid/out_wb/out_rd/out_data=0; stall counter=0; deadlock=0; pending=0.
- Register 0 is never marked busy and never causes a hazard.
- hazard = in_valid && (busy[in_wid][rsK] for any K with in_rs_used[K], or in_wb && busy[in_wid][in_rd]). Reading an unused rs field never stalls.
- slot_free = !out_valid || out_ready.
- in_ready = !hazard && slot_free. in_ready is combinational on inputs and table; it depends on in_valid only through hazard.
- Fire = in_valid && in_ready. On fire:
  - Output register loads in_* next cycle; out_valid=1.
  - If in_wb and in_rd!=0, set busy[in_wid][in_rd].
- Output handshake: out_valid && out_ready with no fire clears out_valid. Fire together with out_ready replaces the entry, giving back-to-back throughput of 1 per cycle. While out_valid && !out_ready, fields hold stable.
- Latency: accept cycle N -> out_valid in cycle N+1.
- Release: wb_valid && wb_eop clears busy[wb_wid][wb_rd] at the next edge. wb_valid without wb_eop changes nothing.
- Same-cycle set and release of the same bit: set wins (bit ends at 1).
- Without bypass, the hazard check uses the pre-release table, so an instruction waiting on a register releasing this cycle issues next cycle.
- Releasing a bit that is already 0 is a no-op.
- pending[w] = OR of busy[w][*], registered view of the table.
- Stall counter: increments each cycle in_valid && hazard; resets to 0 on fire or when !in_valid. When it reaches TIMEOUT, deadlock is set and held until reset.
- Stalls due only to !slot_free do not count.
- Reset mid-operation discards the output entry and all busy bits; no release events are needed afterwards.

Optional Feature:
- Macro: SCOREBOARD_BYPASS_EN.
- Defined: hazard evaluates the table with the same-cycle release (wb_valid && wb_eop) already applied. A dependent instruction fires in the release cycle, giving one cycle less latency.
- If that instruction's rd equals the released register, the set wins and the bit stays 1.
- Undefined: behaviour as above, with no combinational path from wb_* to in_ready.

Test Plan:
- Reset, then in_valid=1, wid=0, wb=1, rd=5 -> in_ready=1; next cycle out_valid=1, out_rd=5, pending=4'b0001.
- Warp 0 rd=5 busy; warp 0 inst with rs1=5, rs_used=001 -> in_ready=0. Warp 1 inst with rs1=5 -> in_ready=1.
- Warp 0 rd=5 busy; wb_valid=1, wb_eop=1, wb_rd=5 in cycle N while dependent inst waits:
  - Without bypass: fires in N+1.
  - With SCOREBOARD_BYPASS_EN: fires in N.
- rd=0 with wb=1 issued, then inst reading rs1=0 -> no stall; pending stays 0.
- out_ready=0 for 3 cycles with a second valid inst -> in_ready=0, out_data stable, stall counter stays 0. On out_ready=1, back-to-back issue of 1 per cycle.
- Hazard held with no release for TIMEOUT(=1023) cycles -> deadlock=1 at cycle 1023 and stays 1. Reset clears deadlock, out_valid and pending.

Source files
------------

// File: rtl/mx_scoreboard.sv
// mx_scoreboard: per-warp register busy table gating ibuffer issue into a one-entry output register.
// Latency: instruction accepted in cycle N appears on out_valid in cycle N+1.
// Backpressure: in_ready drops on a register hazard or while a held output entry is not taken.
// Optional macro SCOREBOARD_BYPASS_EN: hazard check sees same-cycle writeback releases.
module mx_scoreboard #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 32,
  parameter int DATAW     = 64,
  parameter int TIMEOUT   = 1023,
  localparam int WID_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int NR_BITS  = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WID_W-1:0]   in_wid,
  input  logic               in_wb,
  input  logic [NR_BITS-1:0] in_rd,
  input  logic [NR_BITS-1:0] in_rs1,
  input  logic [NR_BITS-1:0] in_rs2,
  input  logic [NR_BITS-1:0] in_rs3,
  input  logic [2:0]         in_rs_used,
  input  logic [DATAW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WID_W-1:0]   out_wid,
  output logic               out_wb,
  output logic [NR_BITS-1:0] out_rd,
  output logic [DATAW-1:0]   out_data,
  input  logic               wb_valid,
  input  logic [WID_W-1:0]   wb_wid,
  input  logic [NR_BITS-1:0] wb_rd,
  input  logic               wb_eop,
  output logic [NUM_WARPS-1:0] pending,
  output logic               deadlock
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [NUM_REGS-1:0] r_busy     [NUM_WARPS];
  logic [NUM_REGS-1:0] w_busy_nxt [NUM_WARPS];
  logic [NUM_REGS-1:0] w_row;
  logic [NUM_REGS-1:0] w_rel_mask;
  logic                w_release;
  logic                w_hazard;
  logic                w_slot_free;
  logic                w_fire;
  logic                w_set;

  logic                r_out_valid;
  logic [WID_W-1:0]    r_out_wid;
  logic                r_out_wb;
  logic [NR_BITS-1:0]  r_out_rd;
  logic [DATAW-1:0]    r_out_data;

  logic [CNT_W-1:0]    r_stall_cnt;
  logic                r_deadlock;

  // Only the last writeback of an instruction frees its destination.
  assign w_release  = wb_valid && wb_eop;
  assign w_rel_mask = w_release ? (NUM_REGS'(1) << wb_rd) : '0;

  // Busy row of the issuing warp as seen by the hazard check; register 0 is never a hazard.
  always_comb begin
    w_row = r_busy[in_wid];
`ifdef SCOREBOARD_BYPASS_EN
    if (wb_wid == in_wid) begin
      w_row = w_row & ~w_rel_mask;
    end
`endif
    w_row[0] = 1'b0;
  end

  assign w_hazard = in_valid && ((in_rs_used[0] && w_row[in_rs1]) ||
                                 (in_rs_used[1] && w_row[in_rs2]) ||
                                 (in_rs_used[2] && w_row[in_rs3]) ||
                                 (in_wb && w_row[in_rd]));

  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = !w_hazard && w_slot_free;
  assign w_fire      = in_valid && in_ready;
  assign w_set       = w_fire && in_wb && (in_rd != '0);

  // Next busy table: release first, then issue-set so a same-cycle set wins.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_busy_nxt[w] = r_busy[w];
      if (wb_wid == WID_W'(w)) begin
        w_busy_nxt[w] = w_busy_nxt[w] & ~w_rel_mask;
      end
      if (w_set && (in_wid == WID_W'(w))) begin
        w_busy_nxt[w][in_rd] = 1'b1;
      end
    end
  end

  // Busy table register; reset drops all outstanding writebacks.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_busy[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_busy[w] <= w_busy_nxt[w];
      end
    end
  end

  // Per-warp summary of outstanding writebacks, taken from the registered table.
  always_comb begin
    pending = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      pending[w] = |r_busy[w];
    end
  end

  // One-entry output register: load on fire, drain on out_ready, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_wid   <= '0;
      r_out_wb    <= 1'b0;
      r_out_rd    <= '0;
      r_out_data  <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_wid   <= in_wid;
      r_out_wb    <= in_wb;
      r_out_rd    <= in_rd;
      r_out_data  <= in_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Count consecutive hazard stalls; sticky deadlock once the count reaches TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_deadlock  <= 1'b0;
    end else begin
      if (!in_valid || w_fire) begin
        r_stall_cnt <= '0;
      end else if (w_hazard && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_hazard && (r_stall_cnt >= CNT_MAX - CNT_W'(1))) begin
        r_deadlock <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_wid   = r_out_wid;
  assign out_wb    = r_out_wb;
  assign out_rd    = r_out_rd;
  assign out_data  = r_out_data;
  assign deadlock  = r_deadlock;

endmodule

// File: tb/tb_mx_scoreboard.sv
// tb_mx_scoreboard: scenario tasks for mx_scoreboard with an output scoreboard queue.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Issued instructions are queued by the bench and matched in order against out_* handshakes.
module tb_mx_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wid;
  logic        in_wb;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rs3;
  logic [2:0]  in_rs_used;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_wid;
  logic        out_wb;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic        wb_valid;
  logic [1:0]  wb_wid;
  logic [4:0]  wb_rd;
  logic        wb_eop;
  logic [3:0]  pending;
  logic        deadlock;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  wid;
    logic        wb;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  always #5 clk = ~clk;

  mx_scoreboard dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_wb(in_wb), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_rs_used(in_rs_used), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_wb(out_wb),
    .out_rd(out_rd), .out_data(out_data),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
    .pending(pending), .deadlock(deadlock)
  );

  // Output monitor: every taken output must match the oldest queued issue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got wid=%0d rd=%0d data=%h, expected no output", out_wid, out_rd, out_data);
      end else begin
        m_e = q.pop_front();
        if ({out_wid, out_wb, out_rd, out_data} !== m_e) begin
          bad++;
          $display("FAIL out_fields: got wid=%0d wb=%0b rd=%0d data=%h, expected wid=%0d wb=%0b rd=%0d data=%h",
                   out_wid, out_wb, out_rd, out_data, m_e.wid, m_e.wb, m_e.rd, m_e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wid, input logic wb, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                       input logic [2:0] used, input logic [63:0] data);
    in_valid   = 1'b1;
    in_wid     = wid;
    in_wb      = wb;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rs3     = rs3;
    in_rs_used = used;
    in_data    = data;
  endtask

  // Check in_ready for the currently driven instruction and queue it if it should fire.
  task automatic expect_accept(input string name, input logic exp);
    @(negedge clk);
    total++;
    if (in_ready !== exp) begin
      bad++;
      $display("FAIL %s: in_ready=%0b expected %0b", name, in_ready, exp);
    end
    if (exp) q.push_back({in_wid, in_wb, in_rd, in_data});
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    total++;
    if ({out_wid, out_wb, out_rd, out_data} !== 72'd0) begin
      bad++; $display("FAIL reset_out_fields: got rd=%0d data=%h expected all zero", out_rd, out_data);
    end
    total++;
    if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending: got %b expected 0000", pending); end
    total++;
    if (deadlock !== 1'b0) begin bad++; $display("FAIL reset_deadlock: got %0b expected 0", deadlock); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_issue();
    drive(2'd0, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 64'hA5A5_0000_0000_0001);
    expect_accept("issue_first", 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL issue_out_valid: got %0b expected 1", out_valid); end
    total++;
    if (pending !== 4'b0001) begin bad++; $display("FAIL issue_pending: got %b expected 0001", pending); end
    step();
  endtask

  task automatic test_hazard_warp();
    drive(2'd0, 1'b0, 5'd7, 5'd5, 5'd0, 5'd0, 3'b001, 64'h11);
    expect_accept("raw_rs1_warp0", 1'b0);
    drive(2'd1, 1'b0, 5'd7, 5'd5, 5'd0, 5'd0, 3'b001, 64'h12);
    expect_accept("raw_rs1_warp1", 1'b1);
    drive(2'd0, 1'b0, 5'd7, 5'd9, 5'd5, 5'd0, 3'b001, 64'h13);
    expect_accept("unused_rs2", 1'b1);
    drive(2'd0, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 64'h14);
    expect_accept("waw_rd", 1'b0);
    drive(2'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd5, 3'b100, 64'h15);
    expect_accept("raw_rs3", 1'b0);
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_release();
    drive(2'd0, 1'b0, 5'd8, 5'd5, 5'd0, 5'd0, 3'b001, 64'h21);
    wb_valid = 1'b1; wb_eop = 1'b0; wb_wid = 2'd0; wb_rd = 5'd5;
    expect_accept("release_no_eop", 1'b0);
    wb_eop = 1'b1;
`ifdef SCOREBOARD_BYPASS_EN
    expect_accept("release_bypass", 1'b1);
    wb_valid = 1'b0; wb_eop = 1'b0;
`else
    expect_accept("release_same_cycle", 1'b0);
    wb_valid = 1'b0; wb_eop = 1'b0;
    expect_accept("release_next_cycle", 1'b1);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (pending !== 4'b0000) begin bad++; $display("FAIL release_pending: got %b expected 0000", pending); end
    step();
    // Issue writing w2 r9 while a release of that same (idle) bit arrives: set wins.
    drive(2'd2, 1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 3'b000, 64'h22);
    wb_valid = 1'b1; wb_eop = 1'b1; wb_wid = 2'd2; wb_rd = 5'd9;
    expect_accept("set_vs_release", 1'b1);
    wb_valid = 1'b0; wb_eop = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (pending !== 4'b0100) begin bad++; $display("FAIL set_wins_pending: got %b expected 0100", pending); end
    step();
    wb_valid = 1'b1; wb_eop = 1'b1; wb_wid = 2'd2; wb_rd = 5'd9;
    step();
    wb_valid = 1'b0; wb_eop = 1'b0;
    @(negedge clk);
    total++;
    if (pending !== 4'b0000) begin bad++; $display("FAIL w2_release_pending: got %b expected 0000", pending); end
    step();
  endtask

  task automatic test_rd0();
    drive(2'd3, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 64'h31);
    expect_accept("rd0_issue", 1'b1);
    drive(2'd3, 1'b0, 5'd6, 5'd0, 5'd0, 5'd0, 3'b001, 64'h32);
    expect_accept("rd0_read_rs1", 1'b1);
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_eop = 1'b1; wb_wid = 2'd3; wb_rd = 5'd4;
    step();
    wb_valid = 1'b0; wb_eop = 1'b0;
    @(negedge clk);
    total++;
    if (pending !== 4'b0000) begin bad++; $display("FAIL rd0_pending: got %b expected 0000", pending); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(2'd1, 1'b0, 5'd3, 5'd0, 5'd0, 5'd0, 3'b000, 64'hD1D1_D1D1);
    expect_accept("bp_first", 1'b1);
    drive(2'd1, 1'b0, 5'd4, 5'd0, 5'd0, 5'd0, 3'b000, 64'hD2D2_D2D2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", i, in_ready); end
      total++;
      if (out_data !== 64'hD1D1_D1D1) begin bad++; $display("FAIL bp_hold_data[%0d]: got %h expected d1d1d1d1", i, out_data); end
      total++;
      if (dut.r_stall_cnt !== '0) begin bad++; $display("FAIL bp_stall_cnt[%0d]: got %0d expected 0", i, dut.r_stall_cnt); end
      step();
    end
    out_ready = 1'b1;
    expect_accept("bp_resume", 1'b1);
    drive(2'd2, 1'b0, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 64'hD3D3_D3D3);
    expect_accept("b2b_first", 1'b1);
    drive(2'd3, 1'b0, 5'd6, 5'd0, 5'd0, 5'd0, 3'b000, 64'hD4D4_D4D4);
    expect_accept("b2b_second", 1'b1);
    in_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_deadlock();
    drive(2'd0, 1'b1, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 64'h41);
    expect_accept("dl_set_busy", 1'b1);
    drive(2'd0, 1'b0, 5'd6, 5'd5, 5'd0, 5'd0, 3'b001, 64'h42);
    for (int i = 1; i <= 1022; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL dl_in_ready: got %0b expected 0", in_ready); end
      end
      step();
    end
    @(negedge clk);
    total++;
    if (deadlock !== 1'b0) begin bad++; $display("FAIL dl_early: got %0b expected 0 before stall 1023", deadlock); end
    step();
    @(negedge clk);
    total++;
    if (deadlock !== 1'b1) begin bad++; $display("FAIL dl_raised: got %0b expected 1 after stall 1023", deadlock); end
    in_valid = 1'b0;
    step();
    repeat (3) step();
    @(negedge clk);
    total++;
    if (deadlock !== 1'b1) begin bad++; $display("FAIL dl_sticky: got %0b expected 1", deadlock); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(2'd1, 1'b1, 5'd4, 5'd0, 5'd0, 5'd0, 3'b000, 64'h51);
    expect_accept("mid_issue", 1'b1);
    in_valid = 1'b0;
    reset = 1'b1;
    q.delete();
    step();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %0b expected 0", out_valid); end
    total++;
    if (pending !== 4'b0000) begin bad++; $display("FAIL mid_pending: got %b expected 0000", pending); end
    total++;
    if (deadlock !== 1'b0) begin bad++; $display("FAIL mid_deadlock: got %0b expected 0", deadlock); end
    total++;
    if (out_data !== 64'd0) begin bad++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    drive(2'd0, 1'b0, 5'd7, 5'd5, 5'd0, 5'd0, 3'b001, 64'h52);
    expect_accept("post_reset_rs1", 1'b1);
    drive(2'd1, 1'b1, 5'd4, 5'd0, 5'd0, 5'd0, 3'b000, 64'h53);
    expect_accept("post_reset_rd", 1'b1);
    in_valid = 1'b0;
    step();
    step();
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL queue_drain: %0d outputs missing, expected 0", q.size()); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_wb = 1'b0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_rs_used = '0; in_data = '0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_eop = 1'b0;
    test_reset();
    test_issue();
    test_hazard_warp();
    test_release();
    test_rd0();
    test_backpressure();
    test_deadlock();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
